// File: rtl/uart_wb_bridge.sv
// UART command frames in, single 32-bit Wishbone read/write cycles out, response bytes back.
// Optional bus timeout enabled by defining UART_WB_BRIDGE_TIMEOUT_EN.
`timescale 1ns/1ps

module uart_wb_bridge #(
  parameter int unsigned WB_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_rx_valid,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_frame_err,
  output logic        o_tx_valid,
  output logic [7:0]  o_tx_data,
  input  logic        i_tx_ready,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [3:0]  o_wb_sel,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  input  logic        i_wb_ack,
  input  logic [31:0] i_wb_dat,
  output logic        o_busy,
  output logic        o_overrun
);

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, BUS, RESP} state_t;

  state_t      state, state_next;
  logic [1:0]  byte_cnt;
  logic [31:0] resp_shift;
  logic [2:0]  resp_left;
  logic        rx_ok, is_opcode, last_byte, tx_accept, bus_timeout;

  // A framing error in the same cycle as a byte discards that byte.
  assign rx_ok     = i_rx_valid & ~i_rx_frame_err;
  assign is_opcode = (i_rx_data == 8'h57) || (i_rx_data == 8'h52);
  assign last_byte = rx_ok && (byte_cnt == 2'd3);
  assign tx_accept = o_tx_valid & i_tx_ready;

`ifdef UART_WB_BRIDGE_TIMEOUT_EN
  logic [15:0] to_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      to_cnt <= 16'd0;
    else if (state != BUS)
      to_cnt <= 16'd0;
    else if (!i_wb_ack)
      to_cnt <= to_cnt + 16'd1;
  end

  assign bus_timeout = (state == BUS) && !i_wb_ack && (to_cnt == 16'(WB_TIMEOUT - 1));
`else
  logic [15:0] unused_wb_timeout;
  assign unused_wb_timeout = 16'(WB_TIMEOUT);
  assign bus_timeout       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:
        if (rx_ok)
          state_next = is_opcode ? ADDR : RESP;
      ADDR:
        if (i_rx_frame_err)
          state_next = IDLE;
        else if (last_byte)
          state_next = o_wb_we ? WDATA : BUS;
      WDATA:
        if (i_rx_frame_err)
          state_next = IDLE;
        else if (last_byte)
          state_next = BUS;
      BUS:
        if (i_wb_ack || bus_timeout)
          state_next = RESP;
      RESP:
        if (tx_accept && (resp_left == 3'd0))
          state_next = IDLE;
      default:
        state_next = IDLE;
    endcase
  end

  // Bus strobes and busy are registered from the next state so they track it with no extra latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_wb_cyc   <= 1'b0;
      o_wb_stb   <= 1'b0;
      o_wb_we    <= 1'b0;
      o_wb_sel   <= 4'h0;
      o_wb_adr   <= 32'h0;
      o_wb_dat   <= 32'h0;
      o_tx_valid <= 1'b0;
      o_tx_data  <= 8'h0;
      o_busy     <= 1'b0;
      o_overrun  <= 1'b0;
      byte_cnt   <= 2'd0;
      resp_shift <= 32'h0;
      resp_left  <= 3'd0;
    end else begin
      o_wb_cyc  <= (state_next == BUS);
      o_wb_stb  <= (state_next == BUS);
      o_wb_sel  <= {4{state_next == BUS}};
      o_busy    <= (state_next != IDLE);
      o_overrun <= 1'b0;
      unique case (state)
        IDLE:
          if (rx_ok) begin
            if (is_opcode) begin
              o_wb_we  <= (i_rx_data == 8'h57);
              byte_cnt <= 2'd0;
            end else begin
              resp_shift <= {8'h15, 24'h0};
              resp_left  <= 3'd1;
            end
          end
        ADDR:
          if (rx_ok) begin
            o_wb_adr <= {o_wb_adr[23:0], i_rx_data};
            byte_cnt <= byte_cnt + 2'd1;
          end
        WDATA:
          if (rx_ok) begin
            o_wb_dat <= {o_wb_dat[23:0], i_rx_data};
            byte_cnt <= byte_cnt + 2'd1;
          end
        BUS: begin
          o_overrun <= rx_ok;
          if (i_wb_ack) begin
            resp_shift <= o_wb_we ? {8'h06, 24'h0} : i_wb_dat;
            resp_left  <= o_wb_we ? 3'd1 : 3'd4;
          end else if (bus_timeout) begin
            resp_shift <= {8'h15, 24'h0};
            resp_left  <= 3'd1;
          end
        end
        RESP: begin
          o_overrun <= rx_ok;
          // resp_left counts bytes not yet presented; the MSB of resp_shift is the next one.
          if (!o_tx_valid || (i_tx_ready && (resp_left != 3'd0))) begin
            o_tx_valid <= 1'b1;
            o_tx_data  <= resp_shift[31:24];
            resp_shift <= {resp_shift[23:0], 8'h0};
            resp_left  <= resp_left - 3'd1;
          end else if (i_tx_ready) begin
            o_tx_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_wb_bridge.sv
// Directed self-checking bench for uart_wb_bridge: write, read, bad opcode, frame abort,
// bus stall/timeout, overrun and asynchronous reset during BUS and RESP.
`timescale 1ns/1ps

module tb_uart_wb_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h0;
  logic        rx_frame_err = 1'b0;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        wb_cyc, wb_stb, wb_we;
  logic [3:0]  wb_sel;
  logic [31:0] wb_adr, wb_wdat;
  logic        wb_ack = 1'b0;
  logic [31:0] wb_rdat = 32'h0;
  logic        busy, overrun;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc_seen = 0;
  int tx_seen = 0;

  always #5 clk = ~clk;

  uart_wb_bridge #(
`ifdef UART_WB_BRIDGE_TIMEOUT_EN
    .WB_TIMEOUT(16)
`else
    .WB_TIMEOUT(255)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_rx_valid(rx_valid), .i_rx_data(rx_data), .i_rx_frame_err(rx_frame_err),
    .o_tx_valid(tx_valid), .o_tx_data(tx_data), .i_tx_ready(tx_ready),
    .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we), .o_wb_sel(wb_sel),
    .o_wb_adr(wb_adr), .o_wb_dat(wb_wdat), .i_wb_ack(wb_ack), .i_wb_dat(wb_rdat),
    .o_busy(busy), .o_overrun(overrun)
  );

  always @(negedge clk) begin
    if (wb_cyc) cyc_seen++;
    if (tx_valid) tx_seen++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drives one rx byte pulse; returns on the falling edge after it was sampled.
  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic sendFrame(input logic [7:0] op, input logic [31:0] adr, input logic [31:0] dat);
    applyStimulus(op);
    for (int i = 3; i >= 0; i--) applyStimulus(adr[i*8 +: 8]);
    if (op == 8'h57)
      for (int i = 3; i >= 0; i--) applyStimulus(dat[i*8 +: 8]);
  endtask

  task automatic ackBus(input logic [31:0] d);
    @(negedge clk);
    wb_ack  = 1'b1;
    wb_rdat = d;
    @(negedge clk);
    wb_ack  = 1'b0;
  endtask

  // Collects n response bytes with a randomly toggling ready, bounded in cycles.
  task automatic recvBytes(input int n, output logic [31:0] word, output int got);
    word = 32'h0;
    got  = 0;
    for (int c = 0; c < 300 && got < n; c++) begin
      @(negedge clk);
      tx_ready = 1'($urandom_range(0, 1));
      if (tx_valid && tx_ready) begin
        word = {word[23:0], tx_data};
        got++;
      end
    end
    @(negedge clk);
    tx_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] word;
    int          got, n, cyc0, tx0;

    #12;
    checkOutput("reset wb", {wb_cyc, wb_stb, wb_we, wb_sel}, 32'h0);
    checkOutput("reset adr", wb_adr, 32'h0);
    checkOutput("reset dat", wb_wdat, 32'h0);
    checkOutput("reset misc", {tx_valid, tx_data, busy, overrun}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Write frame with exact response timing
    sendFrame(8'h57, 32'h3000_0004, 32'h1234_5678);
    checkOutput("wr cyc/stb/we", {wb_cyc, wb_stb, wb_we}, 32'h7);
    checkOutput("wr sel", wb_sel, 32'hF);
    checkOutput("wr adr", wb_adr, 32'h3000_0004);
    checkOutput("wr dat", wb_wdat, 32'h1234_5678);
    @(negedge clk);
    checkOutput("wr waiting ack", wb_stb, 32'h1);
    ackBus(32'h0);
    checkOutput("wr cyc after ack", wb_cyc, 32'h0);
    checkOutput("wr tx not yet", tx_valid, 32'h0);
    @(negedge clk);
    checkOutput("wr tx byte", {tx_valid, tx_data}, {23'h0, 1'b1, 8'h06});
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    checkOutput("wr idle after accept", {busy, tx_valid}, 32'h0);

    // Read frame, slave acks after 3 cycles
    sendFrame(8'h52, 32'h3000_0008, 32'h0);
    checkOutput("rd we/adr", {wb_cyc, wb_we}, 32'h2);
    checkOutput("rd adr", wb_adr, 32'h3000_0008);
    repeat (2) @(negedge clk);
    ackBus(32'hDEAD_BEEF);
    checkOutput("rd cyc after ack", {wb_cyc, tx_valid}, 32'h0);
    recvBytes(4, word, got);
    checkOutput("rd byte count", got, 32'd4);
    checkOutput("rd data", word, 32'hDEAD_BEEF);
    checkOutput("rd idle", {busy, tx_valid}, 32'h0);

    // Unknown opcode
    cyc0 = cyc_seen;
    applyStimulus(8'h41);
    checkOutput("bad op busy", busy, 32'h1);
    recvBytes(1, word, got);
    checkOutput("bad op resp", {got[7:0], word[7:0]}, {16'h0, 8'd1, 8'h15});
    checkOutput("bad op no bus", cyc_seen - cyc0, 32'd0);
    checkOutput("bad op idle", busy, 32'h0);

    // Frame error mid-address aborts silently
    cyc0 = cyc_seen;
    tx0  = tx_seen;
    applyStimulus(8'h57);
    applyStimulus(8'h30);
    applyStimulus(8'h00);
    @(negedge clk);
    rx_frame_err = 1'b1;
    @(negedge clk);
    rx_frame_err = 1'b0;
    checkOutput("ferr idle", busy, 32'h0);
    repeat (3) @(negedge clk);
    checkOutput("ferr no bus", cyc_seen - cyc0, 32'd0);
    checkOutput("ferr no tx", tx_seen - tx0, 32'd0);
    sendFrame(8'h52, 32'h3000_000C, 32'h0);
    checkOutput("ferr next adr", wb_adr, 32'h3000_000C);
    ackBus(32'hCAFE_F00D);
    recvBytes(4, word, got);
    checkOutput("ferr next data", word, 32'hCAFE_F00D);

    // Stalled slave: timeout when enabled, indefinite wait otherwise
    sendFrame(8'h52, 32'h3000_0010, 32'h0);
`ifdef UART_WB_BRIDGE_TIMEOUT_EN
    n = 0;
    for (int i = 0; i < 100 && wb_stb; i++) begin
      n++;
      @(negedge clk);
    end
    checkOutput("timeout stb cycles", n, 32'd16);
    recvBytes(1, word, got);
    checkOutput("timeout resp", {got[7:0], word[7:0]}, {16'h0, 8'd1, 8'h15});
`else
    n = 0;
    for (int i = 0; i < 300; i++) begin
      if (wb_stb) n++;
      @(negedge clk);
    end
    checkOutput("stall stb cycles", n, 32'd300);
    ackBus(32'h0BAD_F00D);
    recvBytes(4, word, got);
    checkOutput("stall data", word, 32'h0BAD_F00D);
`endif

    // Overrun during BUS, then reset while the cycle is open
    sendFrame(8'h52, 32'h3000_0014, 32'h0);
    applyStimulus(8'hAA);
    checkOutput("overrun pulse", overrun, 32'h1);
    @(negedge clk);
    checkOutput("overrun single", overrun, 32'h0);
    checkOutput("overrun bus kept", wb_stb, 32'h1);
    #2 rst_n = 1'b0;
    #1 checkOutput("rst in bus", {wb_cyc, wb_stb, busy, wb_sel}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset while a response byte is presented
    sendFrame(8'h52, 32'h3000_0018, 32'h0);
    ackBus(32'h0102_0304);
    @(negedge clk);
    checkOutput("resp presented", {tx_valid, tx_data}, {23'h0, 1'b1, 8'h01});
    #2 rst_n = 1'b0;
    #1 checkOutput("rst in resp", {tx_valid, tx_data, busy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(8'h41);
    recvBytes(1, word, got);
    checkOutput("after reset resp", word[7:0], 32'h15);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_wb_bridge.md
# uart_wb_bridge

UART-to-Wishbone host bridge: decodes command frames from the UART byte receiver and issues single 32-bit Wishbone master read/write cycles onto the user-project bus, including the 0x3000_00xx UART CSR region. Response bytes are returned through the UART transmitter's byte handshake. The bridge sits between the uart_receive/uart_transmission byte interfaces and the Wishbone interconnect, acting as the initiator for slaves such as the UART ctrl block.

## Interface
- WB_TIMEOUT, 255: bus-cycle timeout in clk cycles (used only with the timeout feature), 1..65535
- clk  in  1  single clock for all logic
- rst_n  in  1  asynchronous active-low reset
- i_rx_valid  in  1  one-cycle pulse: i_rx_data holds a received byte
- i_rx_data  in  8  received byte
- i_rx_frame_err  in  1  one-cycle pulse: receiver framing error
- o_tx_valid  out  1  response byte available
- o_tx_data  out  8  response byte, stable while o_tx_valid=1
- i_tx_ready  in  1  transmitter accepts byte when o_tx_valid & i_tx_ready
- o_wb_cyc, o_wb_stb  out  1 each  Wishbone cycle/strobe (always equal)
- o_wb_we  out  1  1=write
- o_wb_sel  out  4  always 4'hF during a cycle
- o_wb_adr  out  32  address
- o_wb_dat  out  32  write data
- i_wb_ack  in  1  slave acknowledge
- i_wb_dat  in  32  read data, valid with i_wb_ack
- o_busy  out  1  high in every state except IDLE
- o_overrun  out  1  one-cycle pulse: rx byte dropped

## Operation
- Frame: opcode, 4 address bytes MSB first, then for writes 4 data bytes MSB first. Opcodes: 0x57 write, 0x52 read.
- Responses: write done -> 0x06; read done -> 4 data bytes MSB first; error -> 0x15.
- States: IDLE, ADDR, WDATA, BUS, RESP.
- IDLE: on rx byte 0x57/0x52 latch we, clear byte counter, go ADDR. Any other byte: load 0x15 into response, go RESP.
- ADDR: shift each byte into address register (adr <= {adr[23:0], byte}); after 4th byte go WDATA if write else BUS.
- WDATA: same shifting into write-data register; after 4th byte go BUS.
- BUS: cyc/stb/sel asserted; on i_wb_ack latch i_wb_dat (read), load response, go RESP.
- RESP: present bytes one at a time; advance on valid&ready; after last byte accepted go IDLE.
- i_rx_frame_err in ADDR or WDATA: abort to IDLE, no bus cycle, no response. Ignored in other states.
- Rx byte in BUS or RESP: dropped, o_overrun pulses the following cycle.
- i_rx_valid and i_rx_frame_err in the same cycle: frame error wins, byte discarded.
- Byte counter 2 bits, wraps 3->0 on the 4th byte.

## Timing
- Reset values: o_wb_cyc/stb/we=0, o_wb_sel=0, o_wb_adr=0, o_wb_dat=0, o_tx_valid=0, o_tx_data=0, o_busy=0, o_overrun=0; state IDLE.
- All outputs registered.
- o_wb_cyc/stb rise the cycle after the last command byte is sampled.
- Ack sampled at edge N: cyc/stb low after edge N; o_tx_valid high after edge N+1 with first response byte.
- Next response byte valid the cycle after each accept (one idle cycle between bytes allowed but not required: accept at edge M, next byte presented after edge M).
- Bridge returns to IDLE the cycle after the final byte is accepted; a new opcode is accepted from that cycle.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous); partial frame discarded.

## Configuration
- UART_WB_BRIDGE_TIMEOUT_EN defined: 16-bit counter clears on BUS entry, increments each BUS cycle without ack; when it reaches WB_TIMEOUT, cyc/stb drop next edge and response 0x15 is sent. Ack on the same cycle as the limit is reached wins (normal response).
- Not defined: no counter; BUS waits indefinitely for i_wb_ack; WB_TIMEOUT unused.

## Test plan
- Bytes 57 30 00 00 04 12 34 56 78 -> one cycle we=1 adr=0x3000_0004 dat=0x12345678 sel=F; after ack, tx byte 0x06; o_busy low after accept.
- Bytes 52 30 00 00 08, slave acks with 0xDEADBEEF after 3 cycles -> we=0 adr=0x3000_0008; tx bytes DE AD BE EF in order, with i_tx_ready toggling randomly.
- Byte 0x41 in IDLE -> no bus cycle, tx byte 0x15, back to IDLE.
- Bytes 57 30 00, then i_rx_frame_err -> no bus cycle, no tx; following full read frame completes normally.
- With UART_WB_BRIDGE_TIMEOUT_EN, WB_TIMEOUT=16, slave never acks -> stb high exactly 16 cycles, then tx 0x15; without macro, stb stays high indefinitely.
- rst_n low while in BUS and during RESP -> cyc/stb/o_tx_valid low immediately; extra rx byte during BUS pulses o_overrun once.
